// File: rtl/nv_nvdla_cacc_mac_pair_align_pkg.sv
// Shared widths, pd tag bit positions and the per-half FIFO entry layout
// used by the CACC MAC pair alignment stage.
package nv_nvdla_cacc_mac_pair_align_pkg;

  localparam int CMAC_ATOMK_HALF   = 8;
  localparam int CMAC_RESULT_WIDTH = 19;
  localparam int PD_WIDTH          = 9;
  localparam int PD_STRIPE_END     = 7;
  localparam int PD_LAYER_END      = 8;
  localparam int HALF_DATA_W       = CMAC_ATOMK_HALF * CMAC_RESULT_WIDTH;

  typedef struct packed {
    logic [CMAC_ATOMK_HALF-1:0] mask;
    logic                       mode;
    logic [PD_WIDTH-1:0]        pd;
    logic [HALF_DATA_W-1:0]     data;
  } half_entry_t;

  localparam int ENTRY_W = $bits(half_entry_t);

endpackage

// File: rtl/nv_nvdla_cacc_pair_fifo.sv
// Flop-based sync FIFO, head visible combinationally; one-cycle write-to-level latency.
// No backpressure: a push to a full FIFO is taken only when a pop happens in the same cycle.
module nv_nvdla_cacc_pair_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_dat,
  output logic [WIDTH-1:0]       rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             pop_ok, push_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_dat  = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is never read before being written, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/nv_nvdla_cacc_mac_pair_align.sv
// Pairs cmac_a/cmac_b half results into one lane-aligned accumulator entry; 2-edge latency, 1/cycle.
// No backpressure on either side: dropped pushes and tag mismatches raise sticky error flags.
module nv_nvdla_cacc_mac_pair_align
  import nv_nvdla_cacc_mac_pair_align_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic                         mac_a_pvld,
  input  logic [CMAC_ATOMK_HALF-1:0]   mac_a_mask,
  input  logic                         mac_a_mode,
  input  logic [HALF_DATA_W-1:0]       mac_a_data,
  input  logic [PD_WIDTH-1:0]          mac_a_pd,
  input  logic                         mac_b_pvld,
  input  logic [CMAC_ATOMK_HALF-1:0]   mac_b_mask,
  input  logic                         mac_b_mode,
  input  logic [HALF_DATA_W-1:0]       mac_b_data,
  input  logic [PD_WIDTH-1:0]          mac_b_pd,
  input  logic                         err_clr,
  output logic                         accu_pvld,
  output logic [2*CMAC_ATOMK_HALF-1:0] accu_mask,
  output logic                         accu_mode,
  output logic [2*HALF_DATA_W-1:0]     accu_data,
  output logic [PD_WIDTH-1:0]          accu_pd,
  output logic                         err_overflow,
  output logic                         err_mismatch,
  output logic [15:0]                  stripe_cnt,
  output logic [$clog2(DEPTH):0]       fifo_a_lvl,
  output logic [$clog2(DEPTH):0]       fifo_b_lvl
);

  half_entry_t a_in, b_in, a_head, b_head;
  logic        a_full, a_empty, b_full, b_empty;
  logic        pop;

  logic                         accu_pvld_q, accu_pvld_d;
  logic [2*CMAC_ATOMK_HALF-1:0] accu_mask_q, accu_mask_d;
  logic                         accu_mode_q, accu_mode_d;
  logic [2*HALF_DATA_W-1:0]     accu_data_q, accu_data_d;
  logic [PD_WIDTH-1:0]          accu_pd_q, accu_pd_d;
  logic                         err_ovf_q, err_ovf_d;
  logic                         err_mis_q, err_mis_d;
  logic [15:0]                  stripe_cnt_q, stripe_cnt_d;
  logic                         ovf_new, mis_new;

  assign a_in = {mac_a_mask, mac_a_mode, mac_a_pd, mac_a_data};
  assign b_in = {mac_b_mask, mac_b_mode, mac_b_pd, mac_b_data};

  nv_nvdla_cacc_pair_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk    (nvdla_core_clk),
    .rst_n  (nvdla_core_rstn),
    .push   (mac_a_pvld),
    .pop    (pop),
    .wr_dat (a_in),
    .rd_dat (a_head),
    .full   (a_full),
    .empty  (a_empty),
    .level  (fifo_a_lvl)
  );

  nv_nvdla_cacc_pair_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk    (nvdla_core_clk),
    .rst_n  (nvdla_core_rstn),
    .push   (mac_b_pvld),
    .pop    (pop),
    .wr_dat (b_in),
    .rd_dat (b_head),
    .full   (b_full),
    .empty  (b_empty),
    .level  (fifo_b_lvl)
  );

  // Empty flags come from registered levels, so pop never depends on this cycle's pushes.
  assign pop     = !a_empty && !b_empty;
  assign ovf_new = (mac_a_pvld && a_full && !pop) || (mac_b_pvld && b_full && !pop);
  assign mis_new = pop && ((a_head.pd != b_head.pd) || (a_head.mode != b_head.mode));

  always_comb begin
    accu_pvld_d  = pop;
    accu_mask_d  = accu_mask_q;
    accu_mode_d  = accu_mode_q;
    accu_data_d  = accu_data_q;
    accu_pd_d    = accu_pd_q;
    stripe_cnt_d = stripe_cnt_q;
    err_ovf_d    = ovf_new || (err_ovf_q && !err_clr);
    err_mis_d    = mis_new || (err_mis_q && !err_clr);
    if (pop) begin
      accu_mask_d = {b_head.mask, a_head.mask};
      accu_mode_d = a_head.mode;
      accu_data_d = {b_head.data, a_head.data};
      accu_pd_d   = a_head.pd;
      // Layer end restarts the count even when the same entry also ends a stripe.
      if (a_head.pd[PD_LAYER_END])
        stripe_cnt_d = '0;
      else if (a_head.pd[PD_STRIPE_END] && stripe_cnt_q != 16'hFFFF)
        stripe_cnt_d = stripe_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      accu_pvld_q  <= 1'b0;
      accu_mask_q  <= '0;
      accu_mode_q  <= 1'b0;
      accu_data_q  <= '0;
      accu_pd_q    <= '0;
      err_ovf_q    <= 1'b0;
      err_mis_q    <= 1'b0;
      stripe_cnt_q <= '0;
    end else begin
      accu_pvld_q  <= accu_pvld_d;
      accu_mask_q  <= accu_mask_d;
      accu_mode_q  <= accu_mode_d;
      accu_data_q  <= accu_data_d;
      accu_pd_q    <= accu_pd_d;
      err_ovf_q    <= err_ovf_d;
      err_mis_q    <= err_mis_d;
      stripe_cnt_q <= stripe_cnt_d;
    end
  end

  assign accu_pvld    = accu_pvld_q;
  assign accu_mask    = accu_mask_q;
  assign accu_mode    = accu_mode_q;
  assign accu_data    = accu_data_q;
  assign accu_pd      = accu_pd_q;
  assign err_overflow = err_ovf_q;
  assign err_mismatch = err_mis_q;
  assign stripe_cnt   = stripe_cnt_q;

endmodule

// File: tb/tb_nv_nvdla_cacc_mac_pair_align.sv
// Bench for the MAC pair alignment stage: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_nv_nvdla_cacc_mac_pair_align;
  import nv_nvdla_cacc_mac_pair_align_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                         clk;
  logic                         rstn;
  logic                         mac_a_pvld, mac_a_mode, mac_b_pvld, mac_b_mode, err_clr;
  logic [CMAC_ATOMK_HALF-1:0]   mac_a_mask, mac_b_mask;
  logic [HALF_DATA_W-1:0]       mac_a_data, mac_b_data;
  logic [PD_WIDTH-1:0]          mac_a_pd, mac_b_pd;
  logic                         accu_pvld, accu_mode, err_overflow, err_mismatch;
  logic [2*CMAC_ATOMK_HALF-1:0] accu_mask;
  logic [2*HALF_DATA_W-1:0]     accu_data;
  logic [PD_WIDTH-1:0]          accu_pd;
  logic [15:0]                  stripe_cnt;
  logic [LW-1:0]                fifo_a_lvl, fifo_b_lvl;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  half_entry_t              mq_a[$];
  half_entry_t              mq_b[$];
  logic                     m_pvld, m_mode, m_ovf, m_mis;
  logic [2*CMAC_ATOMK_HALF-1:0] m_mask;
  logic [2*HALF_DATA_W-1:0] m_data;
  logic [PD_WIDTH-1:0]      m_pd;
  logic [15:0]              m_cnt;

  half_entry_t idle_e;

  nv_nvdla_cacc_mac_pair_align #(.DEPTH(DEPTH)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .mac_a_pvld     (mac_a_pvld),
    .mac_a_mask     (mac_a_mask),
    .mac_a_mode     (mac_a_mode),
    .mac_a_data     (mac_a_data),
    .mac_a_pd       (mac_a_pd),
    .mac_b_pvld     (mac_b_pvld),
    .mac_b_mask     (mac_b_mask),
    .mac_b_mode     (mac_b_mode),
    .mac_b_data     (mac_b_data),
    .mac_b_pd       (mac_b_pd),
    .err_clr        (err_clr),
    .accu_pvld      (accu_pvld),
    .accu_mask      (accu_mask),
    .accu_mode      (accu_mode),
    .accu_data      (accu_data),
    .accu_pd        (accu_pd),
    .err_overflow   (err_overflow),
    .err_mismatch   (err_mismatch),
    .stripe_cnt     (stripe_cnt),
    .fifo_a_lvl     (fifo_a_lvl),
    .fifo_b_lvl     (fifo_b_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic half_entry_t mk_seq(input logic [PD_WIDTH-1:0] pd, input int base);
    half_entry_t e;
    e.mask = '1;
    e.mode = 1'b0;
    e.pd   = pd;
    e.data = '0;
    for (int i = 0; i < CMAC_ATOMK_HALF; i++)
      e.data[i*CMAC_RESULT_WIDTH +: CMAC_RESULT_WIDTH] = CMAC_RESULT_WIDTH'(base + i);
    return e;
  endfunction

  function automatic half_entry_t mk_rand();
    half_entry_t e;
    e.mask = CMAC_ATOMK_HALF'($urandom);
    e.mode = 1'($urandom);
    e.pd   = PD_WIDTH'($urandom);
    e.data = '0;
    for (int i = 0; i < CMAC_ATOMK_HALF; i++)
      e.data[i*CMAC_RESULT_WIDTH +: CMAC_RESULT_WIDTH] = CMAC_RESULT_WIDTH'($urandom);
    return e;
  endfunction

  task automatic model_clear();
    mq_a.delete();
    mq_b.delete();
    m_pvld = 0; m_mode = 0; m_ovf = 0; m_mis = 0;
    m_mask = '0; m_data = '0; m_pd = '0; m_cnt = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the same edge, sample 1ns later.
  task automatic step(input logic av, input half_entry_t ae, input logic bv,
                      input half_entry_t be, input logic clr);
    half_entry_t ha, hb;
    logic pop, novf, nmis;
    mac_a_pvld = av; mac_a_mask = ae.mask; mac_a_mode = ae.mode; mac_a_pd = ae.pd; mac_a_data = ae.data;
    mac_b_pvld = bv; mac_b_mask = be.mask; mac_b_mode = be.mode; mac_b_pd = be.pd; mac_b_data = be.data;
    err_clr = clr;
    @(posedge clk);
    pop  = (mq_a.size() > 0) && (mq_b.size() > 0);
    novf = 1'b0;
    nmis = 1'b0;
    m_pvld = pop;
    if (pop) begin
      ha = mq_a.pop_front();
      hb = mq_b.pop_front();
      m_data = {hb.data, ha.data};
      m_mask = {hb.mask, ha.mask};
      m_mode = ha.mode;
      m_pd   = ha.pd;
      nmis   = (ha.pd != hb.pd) || (ha.mode != hb.mode);
      if (ha.pd[8])                          m_cnt = 16'd0;
      else if (ha.pd[7] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    if (av) begin
      if (mq_a.size() < DEPTH) mq_a.push_back(ae);
      else                     novf = 1'b1;
    end
    if (bv) begin
      if (mq_b.size() < DEPTH) mq_b.push_back(be);
      else                     novf = 1'b1;
    end
    m_ovf = novf | (m_ovf & ~clr);
    m_mis = nmis | (m_mis & ~clr);
    #1;
    mac_a_pvld = 1'b0;
    mac_b_pvld = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    mac_a_pvld = 0; mac_b_pvld = 0; err_clr = 0;
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++;
    if ({accu_pvld, accu_mode, err_overflow, err_mismatch} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {accu_pvld, accu_mode, err_overflow, err_mismatch});
    end
    n_tests++;
    if (accu_data !== '0 || accu_mask !== '0 || accu_pd !== '0) begin
      n_fail++; $display("FAIL reset_payload got mask %h pd %h exp 0", accu_mask, accu_pd);
    end
    n_tests++;
    if ({stripe_cnt, fifo_a_lvl, fifo_b_lvl} !== '0) begin
      n_fail++; $display("FAIL reset_counts got cnt %0d lvl %0d/%0d exp 0", stripe_cnt, fifo_a_lvl, fifo_b_lvl);
    end
  endtask

  task automatic test_lockstep();
    logic [2*HALF_DATA_W-1:0] exp_data;
    apply_reset();
    exp_data = '0;
    for (int i = 0; i < 2*CMAC_ATOMK_HALF; i++)
      exp_data[i*CMAC_RESULT_WIDTH +: CMAC_RESULT_WIDTH] = CMAC_RESULT_WIDTH'(i + 1);
    step(1, mk_seq(9'h080, 1), 1, mk_seq(9'h080, 9), 0);
    n_tests++;
    if (accu_pvld !== 1'b0 || fifo_a_lvl !== LW'(1) || fifo_b_lvl !== LW'(1)) begin
      n_fail++; $display("FAIL lockstep_e0 got pvld %b lvl %0d/%0d exp 0 1/1", accu_pvld, fifo_a_lvl, fifo_b_lvl);
    end
    step(0, idle_e, 0, idle_e, 0);
    n_tests++;
    if (accu_pvld !== 1'b1) begin n_fail++; $display("FAIL lockstep_pvld got %b exp 1", accu_pvld); end
    n_tests++;
    if (accu_data !== exp_data) begin n_fail++; $display("FAIL lockstep_data got %h exp %h", accu_data, exp_data); end
    n_tests++;
    if (accu_mask !== 16'hFFFF || accu_pd !== 9'h080 || stripe_cnt !== 16'd1) begin
      n_fail++; $display("FAIL lockstep_meta got mask %h pd %h cnt %0d exp ffff 080 1", accu_mask, accu_pd, stripe_cnt);
    end
    step(0, idle_e, 0, idle_e, 0);
    n_tests++;
    if (accu_pvld !== 1'b0 || accu_data !== exp_data) begin
      n_fail++; $display("FAIL lockstep_hold got pvld %b exp 0 with data held", accu_pvld);
    end
  endtask

  task automatic test_skew();
    half_entry_t ea[3], eb[3];
    int nout, first;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      ea[i] = mk_rand(); eb[i] = mk_rand();
      eb[i].pd = ea[i].pd; eb[i].mode = ea[i].mode;
    end
    for (int i = 0; i < 3; i++) step(1, ea[i], 0, idle_e, 0);
    n_tests++;
    if (fifo_a_lvl !== LW'(3) || fifo_b_lvl !== LW'(0)) begin
      n_fail++; $display("FAIL skew_level got %0d/%0d exp 3/0", fifo_a_lvl, fifo_b_lvl);
    end
    step(0, idle_e, 0, idle_e, 0);
    step(0, idle_e, 0, idle_e, 0);
    nout = 0; first = -1;
    for (int j = 0; j < 7; j++) begin
      if (j < 3) step(0, idle_e, 1, eb[j], 0);
      else       step(0, idle_e, 0, idle_e, 0);
      if (accu_pvld === 1'b1) begin
        if (first < 0) first = j;
        if (nout < 3) begin
          n_tests++;
          if (accu_data !== {eb[nout].data, ea[nout].data} || accu_pd !== ea[nout].pd) begin
            n_fail++; $display("FAIL skew_payload idx %0d got pd %h exp %h", nout, accu_pd, ea[nout].pd);
          end
        end
        nout++;
      end
    end
    n_tests++;
    if (nout != 3 || first != 1) begin n_fail++; $display("FAIL skew_timing got %0d outs first %0d exp 3 first 1", nout, first); end
    n_tests++;
    if (err_overflow !== 1'b0 || err_mismatch !== 1'b0) begin
      n_fail++; $display("FAIL skew_err got %b%b exp 00", err_overflow, err_mismatch);
    end
  endtask

  task automatic test_overflow();
    half_entry_t pa[5], pb[4];
    int nout;
    apply_reset();
    for (int i = 0; i < 5; i++) pa[i] = mk_rand();
    for (int i = 0; i < 4; i++) begin pb[i] = mk_rand(); pb[i].pd = pa[i].pd; pb[i].mode = pa[i].mode; end
    for (int i = 0; i < 5; i++) step(1, pa[i], 0, idle_e, 0);
    n_tests++;
    if (err_overflow !== 1'b1 || fifo_a_lvl !== LW'(4)) begin
      n_fail++; $display("FAIL ovf_set got err %b lvl %0d exp 1 4", err_overflow, fifo_a_lvl);
    end
    nout = 0;
    for (int j = 0; j < 8; j++) begin
      if (j < 4) step(0, idle_e, 1, pb[j], 0);
      else       step(0, idle_e, 0, idle_e, 0);
      if (accu_pvld === 1'b1) begin
        if (nout < 4) begin
          n_tests++;
          if (accu_data !== {pb[nout].data, pa[nout].data}) begin
            n_fail++; $display("FAIL ovf_payload idx %0d got %h exp %h", nout, accu_data[HALF_DATA_W-1:0], pa[nout].data);
          end
        end
        nout++;
      end
    end
    n_tests++;
    if (nout != 4 || fifo_a_lvl !== LW'(0)) begin n_fail++; $display("FAIL ovf_count got %0d lvl %0d exp 4 0", nout, fifo_a_lvl); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, mk_rand(), 0, idle_e, 0);
    step(0, idle_e, 1, mk_rand(), 0);
    n_tests++;
    if (fifo_a_lvl !== LW'(4) || fifo_b_lvl !== LW'(1)) begin
      n_fail++; $display("FAIL fullpop_fill got %0d/%0d exp 4/1", fifo_a_lvl, fifo_b_lvl);
    end
    step(1, mk_rand(), 0, idle_e, 0);
    n_tests++;
    if (fifo_a_lvl !== LW'(4) || fifo_b_lvl !== LW'(0) || accu_pvld !== 1'b1 || err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_same got lvl %0d/%0d pvld %b ovf %b exp 4/0 1 0",
                         fifo_a_lvl, fifo_b_lvl, accu_pvld, err_overflow);
    end
  endtask

  task automatic test_mismatch();
    apply_reset();
    step(1, mk_seq(9'h080, 100), 1, mk_seq(9'h000, 200), 0);
    step(0, idle_e, 0, idle_e, 0);
    n_tests++;
    if (err_mismatch !== 1'b1 || accu_pd !== 9'h080 || accu_pvld !== 1'b1) begin
      n_fail++; $display("FAIL mis_set got err %b pd %h pvld %b exp 1 080 1", err_mismatch, accu_pd, accu_pvld);
    end
    step(0, idle_e, 0, idle_e, 1);
    n_tests++;
    if (err_mismatch !== 1'b0) begin n_fail++; $display("FAIL mis_clr got %b exp 0", err_mismatch); end
    step(1, mk_seq(9'h080, 300), 1, mk_seq(9'h000, 400), 0);
    step(0, idle_e, 0, idle_e, 1);
    n_tests++;
    if (err_mismatch !== 1'b1) begin n_fail++; $display("FAIL mis_set_wins got %b exp 1", err_mismatch); end
  endtask

  task automatic test_layer_end();
    logic [15:0] exp_cnt[4];
    exp_cnt = '{16'd1, 16'd2, 16'd3, 16'd0};
    apply_reset();
    for (int j = 0; j < 5; j++) begin
      if (j < 4) step(1, mk_seq(j == 3 ? 9'h180 : 9'h080, j*16), 1, mk_seq(j == 3 ? 9'h180 : 9'h080, j*16+8), 0);
      else       step(0, idle_e, 0, idle_e, 0);
      if (j > 0) begin
        n_tests++;
        if (accu_pvld !== 1'b1 || stripe_cnt !== exp_cnt[j-1]) begin
          n_fail++; $display("FAIL layer_cnt step %0d got pvld %b cnt %0d exp 1 %0d", j, accu_pvld, stripe_cnt, exp_cnt[j-1]);
        end
      end
    end
    step(1, mk_rand(), 0, idle_e, 0);
    step(1, mk_rand(), 0, idle_e, 0);
    n_tests++;
    if (fifo_a_lvl !== LW'(2)) begin n_fail++; $display("FAIL layer_prelvl got %0d exp 2", fifo_a_lvl); end
    #2;
    rstn = 1'b0;
    #1;
    n_tests++;
    if (accu_pvld !== 1'b0 || accu_data !== '0 || accu_pd !== '0 || accu_mask !== '0 ||
        stripe_cnt !== '0 || fifo_a_lvl !== '0 || fifo_b_lvl !== '0) begin
      n_fail++; $display("FAIL midreset got pvld %b pd %h cnt %0d lvl %0d/%0d exp all 0",
                         accu_pvld, accu_pd, stripe_cnt, fifo_a_lvl, fifo_b_lvl);
    end
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_random();
    half_entry_t ea, eb;
    logic av, bv, clr;
    int pa, pb, ok_cnt;
    apply_reset();
    ok_cnt = 1;
    for (int c = 0; c < 600; c++) begin
      case ((c / 40) % 3)
        0:       begin pa = 80; pb = 30; end
        1:       begin pa = 30; pb = 80; end
        default: begin pa = 60; pb = 60; end
      endcase
      av  = ($urandom_range(99) < pa);
      bv  = ($urandom_range(99) < pb);
      clr = ($urandom_range(99) < 6);
      ea = mk_rand();
      eb = mk_rand();
      ea.pd[8] = ($urandom_range(9) == 0);
      if ($urandom_range(9) != 0) begin eb.pd = ea.pd; eb.mode = ea.mode; end
      step(av, ea, bv, eb, clr);
      n_tests++;
      if (accu_pvld !== m_pvld || accu_data !== m_data || accu_mask !== m_mask ||
          accu_pd !== m_pd || accu_mode !== m_mode) begin
        n_fail++; $display("FAIL rand_out cyc %0d got pvld %b pd %h mask %h exp pvld %b pd %h mask %h",
                           c, accu_pvld, accu_pd, accu_mask, m_pvld, m_pd, m_mask);
      end
      n_tests++;
      if (err_overflow !== m_ovf || err_mismatch !== m_mis || stripe_cnt !== m_cnt ||
          fifo_a_lvl !== LW'(mq_a.size()) || fifo_b_lvl !== LW'(mq_b.size())) begin
        n_fail++; $display("FAIL rand_state cyc %0d got ovf %b mis %b cnt %0d lvl %0d/%0d exp %b %b %0d %0d/%0d",
                           c, err_overflow, err_mismatch, stripe_cnt, fifo_a_lvl, fifo_b_lvl,
                           m_ovf, m_mis, m_cnt, mq_a.size(), mq_b.size());
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    mac_a_pvld = 0; mac_a_mask = '0; mac_a_mode = 0; mac_a_data = '0; mac_a_pd = '0;
    mac_b_pvld = 0; mac_b_mask = '0; mac_b_mode = 0; mac_b_data = '0; mac_b_pd = '0;
    err_clr = 0;
    idle_e = '0;
    model_clear();
    test_reset();
    test_lockstep();
    test_skew();
    test_overflow();
    test_full_pop();
    test_mismatch();
    test_layer_end();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
